control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit CPU datapath. It replaces the per-instruction testbench step sequencing with one parametrised FSM.
- Each instruction runs a fetch (T0–T2), then an opcode-dependent execute sequence.
- Execute classes: R-type ALU, MUL/DIV with a done handshake and timeout, MFHI/MFLO, IN/OUT, NOP, HALT.
- Sits beside the DataPath and drives all of its control strobes.

---
 rtl/control_pkg.sv | 39 +++
 rtl/control_decode.sv | 33 +++
 rtl/control_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state encoding
// and instruction classes.
package control_pkg;

    // Opcode map (5-bit encodings; narrower/wider OPC_W is cast at the use site)
    localparam logic [4:0] OP_RLO  = 5'b00011;
    localparam logic [4:0] OP_RHI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer state encoding
    localparam logic [3:0] StRst  = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StEx1  = 4'd4;
    localparam logic [3:0] StEx2  = 4'd5;
    localparam logic [3:0] StEx3  = 4'd6;
    localparam logic [3:0] StEx4  = 4'd7;
    localparam logic [3:0] StHalt = 4'd8;

    // Execute-sequence class selected by the opcode
    typedef enum logic [2:0] {
        CLS_R,
        CLS_MD,
        CLS_MF,
        CLS_IO,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } instr_cls_e;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps an opcode onto its execute class and flags
// MFHI (as opposed to MFLO) for the move-from class.
module control_decode
    import control_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] op_i,
    output instr_cls_e       cls_o,
    output logic             sel_hi_o
);

    // Class lookup; anything not listed is undefined
    always_comb begin
        cls_o    = CLS_ILL;
        sel_hi_o = 1'b0;
        if (op_i >= OPC_W'(OP_RLO) && op_i <= OPC_W'(OP_RHI)) begin
            cls_o = CLS_R;
        end else if (op_i == OPC_W'(OP_MUL) || op_i == OPC_W'(OP_DIV)) begin
            cls_o = CLS_MD;
        end else if (op_i == OPC_W'(OP_MFHI) || op_i == OPC_W'(OP_MFLO)) begin
            cls_o    = CLS_MF;
            sel_hi_o = (op_i == OPC_W'(OP_MFHI));
        end else if (op_i == OPC_W'(OP_IN) || op_i == OPC_W'(OP_OUT)) begin
            cls_o = CLS_IO;
        end else if (op_i == OPC_W'(OP_NOP)) begin
            cls_o = CLS_NOP;
        end else if (op_i == OPC_W'(OP_HALT)) begin
            cls_o = CLS_HALT;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit datapath: fetch T0..T2, then an
// opcode-dependent execute sequence. Moore machine; strobes decode from registers.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned OPC_W      = 5,
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             alu_done,
    output logic             PCout,
    output logic             IncPC,
    output logic             MARin,
    output logic             read,
    output logic             RAMenable,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             Yin,
    output logic             ZLOin,
    output logic             ZHIin,
    output logic             ZLOout,
    output logic             ZHIout,
    output logic             HIin,
    output logic             LOin,
    output logic             HIout,
    output logic             LOout,
    output logic [OPC_W-1:0] aluControl,
    output logic             OutPortenable,
    output logic             InPortout,
    output logic             md_start,
    output logic             run,
    output logic             illegal_op,
    output logic             fault
);

    localparam logic [CNT_W-1:0] MemLast = CNT_W'(MEM_WAIT - 1);
    localparam logic [CNT_W-1:0] MdLast  = CNT_W'(MD_TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPC_W-1:0] op_q, op_d;
    instr_cls_e       cls_q, cls_d;
    logic             sel_hi_q, sel_hi_d;
    logic             fault_q, fault_d;

    instr_cls_e       dec_cls;
    logic             dec_sel_hi;
    logic [OPC_W-1:0] ir_op;
    logic             unused_ir;

    assign ir_op     = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];

    control_decode #(
        .OPC_W(OPC_W)
    ) u_decode (
        .op_i    (ir_op),
        .cls_o   (dec_cls),
        .sel_hi_o(dec_sel_hi)
    );

    // Next-state, shared wait counter and held decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        cls_d    = cls_q;
        sel_hi_d = sel_hi_q;
        fault_d  = fault_q;
        case (state_q)
            StRst: begin
                state_d = StT0;
                cnt_d   = '0;
            end
            StT0: begin
                state_d = StT1;
                cnt_d   = '0;
            end
            StT1: begin
                if (cnt_q == MemLast) begin
                    state_d = StT2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StT2: begin
                // Decode is captured on EX1 entry and held for the whole sequence
                state_d  = StEx1;
                op_d     = ir_op;
                cls_d    = dec_cls;
                sel_hi_d = dec_sel_hi;
            end
            StEx1: begin
                cnt_d = '0;
                case (cls_q)
                    CLS_R, CLS_MD: state_d = StEx2;
                    CLS_HALT:      state_d = StHalt;
                    default:       state_d = StT0;
                endcase
            end
            StEx2: begin
                if (cls_q == CLS_MD) begin
                    // alu_done wins over a timeout landing in the same cycle
                    if (alu_done) begin
                        state_d = StEx3;
                        cnt_d   = '0;
                    end else if (cnt_q == MdLast) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StEx3;
                end
            end
            StEx3:   state_d = (cls_q == CLS_MD) ? StEx4 : StT0;
            StEx4:   state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    // State registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= StRst;
            cnt_q    <= '0;
            op_q     <= '0;
            cls_q    <= CLS_NOP;
            sel_hi_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            cls_q    <= cls_d;
            sel_hi_q <= sel_hi_d;
            fault_q  <= fault_d;
        end
    end

    // Moore output decode
    always_comb begin
        PCout         = 1'b0;
        IncPC         = 1'b0;
        MARin         = 1'b0;
        read          = 1'b0;
        RAMenable     = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        IRin          = 1'b0;
        Gra           = 1'b0;
        Grb           = 1'b0;
        Grc           = 1'b0;
        Rin           = 1'b0;
        Rout          = 1'b0;
        Yin           = 1'b0;
        ZLOin         = 1'b0;
        ZHIin         = 1'b0;
        ZLOout        = 1'b0;
        ZHIout        = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        HIout         = 1'b0;
        LOout         = 1'b0;
        aluControl    = '0;
        OutPortenable = 1'b0;
        InPortout     = 1'b0;
        md_start      = 1'b0;
        illegal_op    = 1'b0;
        run           = (state_q != StRst) && (state_q != StHalt);
        fault         = fault_q;
        case (state_q)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            StT1: begin
                read      = 1'b1;
                RAMenable = 1'b1;
                MDRin     = (cnt_q == MemLast);
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StEx1: begin
                case (cls_q)
                    CLS_R: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    CLS_MD: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    CLS_MF: begin
                        HIout = sel_hi_q;
                        LOout = !sel_hi_q;
                        Gra   = 1'b1;
                        Rin   = 1'b1;
                    end
                    CLS_IO: begin
                        Gra = 1'b1;
                        if (op_q == OPC_W'(OP_IN)) begin
                            InPortout = 1'b1;
                            Rin       = 1'b1;
                        end else begin
                            Rout          = 1'b1;
                            OutPortenable = 1'b1;
                        end
                    end
                    CLS_ILL: illegal_op = 1'b1;
                    default: ;
                endcase
            end
            StEx2: begin
                Rout       = 1'b1;
                aluControl = op_q;
                ZLOin      = 1'b1;
                if (cls_q == CLS_MD) begin
                    Grb      = 1'b1;
                    ZHIin    = 1'b1;
                    md_start = (cnt_q == '0);
                end else begin
                    Grc = 1'b1;
                end
            end
            StEx3: begin
                ZLOout = 1'b1;
                if (cls_q == CLS_MD) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            StEx4: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: a per-cycle vector table for a MEM_WAIT=1, MD_TIMEOUT=8 instance,
// plus a hand sequence for a MEM_WAIT=3 instance.
module tb_control_sequencer;

    // Observation bit positions, aluControl sits in [4:0]
    localparam logic [32:0] FLT  = 33'h1 << 5;
    localparam logic [32:0] ILL  = 33'h1 << 6;
    localparam logic [32:0] RUN  = 33'h1 << 7;
    localparam logic [32:0] MDS  = 33'h1 << 8;
    localparam logic [32:0] INP  = 33'h1 << 9;
    localparam logic [32:0] OUTP = 33'h1 << 10;
    localparam logic [32:0] LOO  = 33'h1 << 11;
    localparam logic [32:0] HIO  = 33'h1 << 12;
    localparam logic [32:0] LOI  = 33'h1 << 13;
    localparam logic [32:0] HII  = 33'h1 << 14;
    localparam logic [32:0] ZHO  = 33'h1 << 15;
    localparam logic [32:0] ZLO  = 33'h1 << 16;
    localparam logic [32:0] ZHI  = 33'h1 << 17;
    localparam logic [32:0] ZLI  = 33'h1 << 18;
    localparam logic [32:0] YIN  = 33'h1 << 19;
    localparam logic [32:0] ROUT = 33'h1 << 20;
    localparam logic [32:0] RIN  = 33'h1 << 21;
    localparam logic [32:0] GRC  = 33'h1 << 22;
    localparam logic [32:0] GRB  = 33'h1 << 23;
    localparam logic [32:0] GRA  = 33'h1 << 24;
    localparam logic [32:0] IRI  = 33'h1 << 25;
    localparam logic [32:0] MDRO = 33'h1 << 26;
    localparam logic [32:0] MDRI = 33'h1 << 27;
    localparam logic [32:0] RAME = 33'h1 << 28;
    localparam logic [32:0] RD   = 33'h1 << 29;
    localparam logic [32:0] MARI = 33'h1 << 30;
    localparam logic [32:0] INC  = 33'h1 << 31;
    localparam logic [32:0] PCO  = 33'h1 << 32;

    localparam logic [4:0] O_ADD  = 5'b00011;
    localparam logic [4:0] O_MUL  = 5'b01111;
    localparam logic [4:0] O_DIV  = 5'b10000;
    localparam logic [4:0] O_IN   = 5'b10110;
    localparam logic [4:0] O_OUT  = 5'b10111;
    localparam logic [4:0] O_MFHI = 5'b11000;
    localparam logic [4:0] O_MFLO = 5'b11001;
    localparam logic [4:0] O_NOP  = 5'b11010;
    localparam logic [4:0] O_HALT = 5'b11011;
    localparam logic [4:0] O_BAD  = 5'b11111;

    localparam logic [32:0] E_T0  = PCO | INC | MARI | RUN;
    localparam logic [32:0] E_T1W = RD | RAME | RUN;
    localparam logic [32:0] E_T1F = RD | RAME | MDRI | RUN;
    localparam logic [32:0] E_T2  = MDRO | IRI | RUN;
    localparam logic [32:0] E_MD1 = GRA | ROUT | YIN | RUN;
    localparam logic [32:0] E_MD2 = GRB | ROUT | ZLI | ZHI | RUN;
    localparam logic [32:0] E_MD3 = ZLO | LOI | RUN;
    localparam logic [32:0] E_MD4 = ZHO | HII | RUN;
    localparam logic [32:0] E_R1  = GRB | ROUT | YIN | RUN;
    localparam logic [32:0] E_R2  = GRC | ROUT | ZLI | RUN;
    localparam logic [32:0] E_R3  = ZLO | GRA | RIN | RUN;

    typedef struct {
        logic        clr;
        logic [4:0]  op;
        logic        done;
        logic [32:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear, clear3;
    logic [31:0] ir, ir3;
    logic        alu_done, alu_done3;
    logic [32:0] obs1, obs3;
    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    control_sequencer #(
        .OPC_W(5), .MEM_WAIT(1), .MD_TIMEOUT(8), .CNT_W(7)
    ) dut1 (
        .clock(clock), .clear(clear), .ir(ir), .alu_done(alu_done),
        .PCout(obs1[32]), .IncPC(obs1[31]), .MARin(obs1[30]), .read(obs1[29]),
        .RAMenable(obs1[28]), .MDRin(obs1[27]), .MDRout(obs1[26]), .IRin(obs1[25]),
        .Gra(obs1[24]), .Grb(obs1[23]), .Grc(obs1[22]), .Rin(obs1[21]), .Rout(obs1[20]),
        .Yin(obs1[19]), .ZLOin(obs1[18]), .ZHIin(obs1[17]), .ZLOout(obs1[16]),
        .ZHIout(obs1[15]), .HIin(obs1[14]), .LOin(obs1[13]), .HIout(obs1[12]),
        .LOout(obs1[11]), .aluControl(obs1[4:0]), .OutPortenable(obs1[10]),
        .InPortout(obs1[9]), .md_start(obs1[8]), .run(obs1[7]), .illegal_op(obs1[6]),
        .fault(obs1[5])
    );

    control_sequencer #(
        .OPC_W(5), .MEM_WAIT(3), .MD_TIMEOUT(64), .CNT_W(7)
    ) dut3 (
        .clock(clock), .clear(clear3), .ir(ir3), .alu_done(alu_done3),
        .PCout(obs3[32]), .IncPC(obs3[31]), .MARin(obs3[30]), .read(obs3[29]),
        .RAMenable(obs3[28]), .MDRin(obs3[27]), .MDRout(obs3[26]), .IRin(obs3[25]),
        .Gra(obs3[24]), .Grb(obs3[23]), .Grc(obs3[22]), .Rin(obs3[21]), .Rout(obs3[20]),
        .Yin(obs3[19]), .ZLOin(obs3[18]), .ZHIin(obs3[17]), .ZLOout(obs3[16]),
        .ZHIout(obs3[15]), .HIin(obs3[14]), .LOin(obs3[13]), .HIout(obs3[12]),
        .LOout(obs3[11]), .aluControl(obs3[4:0]), .OutPortenable(obs3[10]),
        .InPortout(obs3[9]), .md_start(obs3[8]), .run(obs3[7]), .illegal_op(obs3[6]),
        .fault(obs3[5])
    );

    task automatic add(input logic c, input logic [4:0] op, input logic d,
                       input logic [32:0] e);
        vec_t v;
        v.clr  = c;
        v.op   = op;
        v.done = d;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Standard MEM_WAIT=1 fetch rows for an instruction with opcode op
    task automatic fetch(input logic [4:0] op);
        add(1'b0, op, 1'b0, E_T1F);
        add(1'b0, op, 1'b0, E_T2);
    endtask

    initial begin
        int lat;
        vec_t s3[$];
        clear = 1'b1; ir = '0; alu_done = 1'b0;
        clear3 = 1'b1; ir3 = '0; alu_done3 = 1'b0;

        // Reset, then MFLO
        add(1'b1, O_NOP, 1'b0, '0);
        add(1'b1, O_NOP, 1'b0, '0);
        add(1'b0, O_MFLO, 1'b0, E_T0);
        fetch(O_MFLO);
        add(1'b0, O_MFLO, 1'b0, LOO | GRA | RIN | RUN);
        // MUL: done seen in the 5th EX2 cycle
        add(1'b0, O_MUL, 1'b0, E_T0);
        fetch(O_MUL);
        add(1'b0, O_MUL, 1'b0, E_MD1);
        add(1'b0, O_MUL, 1'b0, E_MD2 | MDS | 33'(O_MUL));
        for (int i = 0; i < 4; i++) add(1'b0, O_MUL, 1'b0, E_MD2 | 33'(O_MUL));
        add(1'b0, O_MUL, 1'b1, E_MD3);
        add(1'b0, O_MUL, 1'b0, E_MD4);
        // DIV timeout after 8 EX2 cycles, then clear
        add(1'b0, O_DIV, 1'b0, E_T0);
        fetch(O_DIV);
        add(1'b0, O_DIV, 1'b0, E_MD1);
        add(1'b0, O_DIV, 1'b0, E_MD2 | MDS | 33'(O_DIV));
        for (int i = 0; i < 7; i++) add(1'b0, O_DIV, 1'b0, E_MD2 | 33'(O_DIV));
        add(1'b0, O_DIV, 1'b0, FLT);
        add(1'b0, O_DIV, 1'b0, FLT);
        add(1'b1, O_BAD, 1'b0, '0);
        // Undefined opcode
        add(1'b0, O_BAD, 1'b0, E_T0);
        fetch(O_BAD);
        add(1'b0, O_BAD, 1'b0, ILL | RUN);
        // ADD aborted by clear during EX2
        add(1'b0, O_ADD, 1'b0, E_T0);
        fetch(O_ADD);
        add(1'b0, O_ADD, 1'b0, E_R1);
        add(1'b0, O_ADD, 1'b0, E_R2 | 33'(O_ADD));
        add(1'b1, O_ADD, 1'b0, '0);
        // NOP, IN, OUT, MFHI
        add(1'b0, O_NOP, 1'b0, E_T0);
        fetch(O_NOP);
        add(1'b0, O_NOP, 1'b0, RUN);
        add(1'b0, O_IN, 1'b0, E_T0);
        fetch(O_IN);
        add(1'b0, O_IN, 1'b0, INP | GRA | RIN | RUN);
        add(1'b0, O_OUT, 1'b0, E_T0);
        fetch(O_OUT);
        add(1'b0, O_OUT, 1'b0, GRA | ROUT | OUTP | RUN);
        add(1'b0, O_MFHI, 1'b0, E_T0);
        fetch(O_MFHI);
        add(1'b0, O_MFHI, 1'b0, HIO | GRA | RIN | RUN);
        // DIV with done arriving in the timeout cycle: success
        add(1'b0, O_DIV, 1'b0, E_T0);
        fetch(O_DIV);
        add(1'b0, O_DIV, 1'b0, E_MD1);
        add(1'b0, O_DIV, 1'b0, E_MD2 | MDS | 33'(O_DIV));
        for (int i = 0; i < 7; i++) add(1'b0, O_DIV, 1'b0, E_MD2 | 33'(O_DIV));
        add(1'b0, O_DIV, 1'b1, E_MD3);
        add(1'b0, O_DIV, 1'b0, E_MD4);
        // HALT instruction, sticky until clear
        add(1'b0, O_HALT, 1'b0, E_T0);
        fetch(O_HALT);
        add(1'b0, O_HALT, 1'b0, RUN);
        add(1'b0, O_HALT, 1'b0, '0);
        add(1'b0, O_HALT, 1'b0, '0);
        add(1'b1, O_NOP, 1'b0, '0);

        foreach (tbl[i]) begin
            clear    = tbl[i].clr;
            ir       = {tbl[i].op, 27'h2A5_1234};
            alu_done = tbl[i].done;
            @(posedge clock);
            #1;
            check($sformatf("dut1_row%0d", i), obs1, tbl[i].exp);
        end

        // MEM_WAIT=3 ADD: three T1 cycles, MDRin only in the last
        ir3 = {O_ADD, 27'h0123456};
        clear3 = 1'b1;
        @(posedge clock);
        #1;
        check("dut3_reset", obs3, '0);
        clear3 = 1'b0;
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T0});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T1W});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T1W});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T1F});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T2});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_R1});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_R2 | 33'(O_ADD)});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_R3});
        s3.push_back('{1'b0, O_ADD, 1'b0, E_T0});
        foreach (s3[i]) begin
            @(posedge clock);
            #1;
            check($sformatf("dut3_step%0d", i), obs3, s3[i].exp);
        end
        // Latency of the next ADD, bounded wait for the following T0
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (obs3[32] !== 1'b1 && lat < 20);
        check("dut3_latency", 33'(lat), 33'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
